// File: rtl/ibex_cheri_cap_lsu_pkg.sv
// ibex_cheri_cap_lsu_pkg
// Shared types and constants for the CHERI capability load/store unit.
// A memory-format capability is 64 bits wide. It moves over the 32-bit data
// bus as two word beats, low word first.
package ibex_cheri_cap_lsu_pkg;

  // Width of a memory-format capability (without its tag)
  localparam int CAP_MEM_W = 64;

  // Capabilities must be naturally aligned to 8 bytes
  localparam int CAP_MEM_ALIGN_BITS = 3;

  // Access sequencer states: one request/response pair per 32-bit beat
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_LO  = 3'd1,
    WAIT_LO = 3'd2,
    REQ_HI  = 3'd3,
    WAIT_HI = 3'd4,
    DONE    = 3'd5
  } cap_lsu_state_e;

  // True when the byte address sits on a capability boundary
  function automatic logic is_cap_aligned(input logic [31:0] addr);
    return (addr[CAP_MEM_ALIGN_BITS-1:0] == '0);
  endfunction

endpackage

// File: rtl/ibex_cheri_cap_lsu.sv
// ibex_cheri_cap_lsu
// Capability load/store unit that sits directly after the execute stage. It
// takes an effective address and a 64-bit memory-format capability plus its
// tag. It moves the capability to or from data memory as two sequential 32-bit
// bus beats, low word first. The tag travels on a sideband bit. The loaded
// capability and tag go back to writeback, or the unit reports an error or a
// misalignment.
//
// Ports
//   clk_i, rst_i           clock, asynchronous active-high reset
//   req_i, we_i, addr_i    access request (sampled only when not busy)
//   wdata_i, wtag_i        capability and tag to store
//   busy_o, valid_o        access in progress / one-cycle completion pulse
//   rdata_o, rtag_o        loaded capability and tag (loads, with valid_o)
//   err_o, misaligned_o    bus error / address not 8-byte aligned
//   data_*                 32-bit data bus with grant/rvalid handshake
//
// Configuration
//   IBEX_CHERI_CAP_LSU_ERR_ABORT_EN
//     When defined, an error on the low beat ends the access at once, so the
//     high beat is never issued. When undefined, both beats are always
//     issued and the errors of the two beats are ORed together.
module ibex_cheri_cap_lsu
  import ibex_cheri_cap_lsu_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [31:0]          addr_i,
  input  logic [CAP_MEM_W-1:0] wdata_i,
  input  logic                 wtag_i,
  output logic                 busy_o,
  output logic                 valid_o,
  output logic [CAP_MEM_W-1:0] rdata_o,
  output logic                 rtag_o,
  output logic                 err_o,
  output logic                 misaligned_o,
  output logic                 data_req_o,
  input  logic                 data_gnt_i,
  input  logic                 data_rvalid_i,
  input  logic                 data_err_i,
  output logic [31:0]          data_addr_o,
  output logic                 data_we_o,
  output logic [3:0]           data_be_o,
  output logic [31:0]          data_wdata_o,
  output logic                 data_tag_o,
  input  logic [31:0]          data_rdata_i,
  input  logic                 data_tag_i
);

  cap_lsu_state_e state_q;

  // The access is captured in IDLE. These registers stay constant until the
  // access finishes, so the bus sees stable fields through grant stalls.
  logic                          we_q;
  logic [31:CAP_MEM_ALIGN_BITS]  addr_q;
  logic [CAP_MEM_W-1:0]          wdata_q;
  logic                          wtag_q;

  // Low-beat results, held until the high beat completes the access
  logic [31:0]                   rdata_lo_q;
  logic                          tag_lo_q;
  logic                          err_lo_q;

  logic                          hi_sel;
  logic                          err_total;

  // The high half of the access selects word +4 and the upper data half
  assign hi_sel = (state_q == REQ_HI) || (state_q == WAIT_HI);

  // Error seen so far, including a high-beat error on this cycle's response
  assign err_total = err_lo_q | data_err_i;

  // Bus outputs depend only on state and captured registers. This keeps
  // them free of any combinational path from the bus inputs.
  assign busy_o       = (state_q != IDLE);
  assign valid_o      = (state_q == DONE);
  assign data_req_o   = (state_q == REQ_LO) || (state_q == REQ_HI);
  assign data_be_o    = {4{data_req_o}};
  assign data_we_o    = data_req_o & we_q;
  assign data_addr_o  = data_req_o ? {addr_q, hi_sel, 2'b00} : 32'h0;
  assign data_wdata_o = data_we_o ? (hi_sel ? wdata_q[63:32] : wdata_q[31:0]) : 32'h0;
  assign data_tag_o   = data_we_o & wtag_q;

  // Access sequencer. Each beat is a request held until grant, followed by a
  // wait for its response. The result registers are cleared when a new
  // access is accepted, and are loaded when the access completes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wtag_q       <= 1'b0;
      rdata_lo_q   <= '0;
      tag_lo_q     <= 1'b0;
      err_lo_q     <= 1'b0;
      rdata_o      <= '0;
      rtag_o       <= 1'b0;
      err_o        <= 1'b0;
      misaligned_o <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_i) begin
            rdata_o      <= '0;
            rtag_o       <= 1'b0;
            err_o        <= 1'b0;
            err_lo_q     <= 1'b0;
            if (is_cap_aligned(addr_i)) begin
              misaligned_o <= 1'b0;
              we_q         <= we_i;
              addr_q       <= addr_i[31:CAP_MEM_ALIGN_BITS];
              wdata_q      <= wdata_i;
              wtag_q       <= wtag_i;
              state_q      <= REQ_LO;
            end else begin
              // A misaligned access completes without touching the bus
              misaligned_o <= 1'b1;
              state_q      <= DONE;
            end
          end
        end

        REQ_LO: begin
          if (data_gnt_i) begin
            state_q <= WAIT_LO;
          end
        end

        WAIT_LO: begin
          if (data_rvalid_i) begin
            rdata_lo_q <= data_rdata_i;
            tag_lo_q   <= data_tag_i;
            err_lo_q   <= data_err_i;
`ifdef IBEX_CHERI_CAP_LSU_ERR_ABORT_EN
            // A failed low beat makes the high beat pointless, so end here
            if (data_err_i) begin
              err_o   <= 1'b1;
              rdata_o <= '0;
              rtag_o  <= 1'b0;
              state_q <= DONE;
            end else begin
              state_q <= REQ_HI;
            end
`else
            state_q    <= REQ_HI;
`endif
          end
        end

        REQ_HI: begin
          if (data_gnt_i) begin
            state_q <= WAIT_HI;
          end
        end

        WAIT_HI: begin
          if (data_rvalid_i) begin
            err_o <= err_total;
            // A capability is returned only if the whole load succeeded.
            // Any error clears both the data and the tag, so a corrupted
            // half can never be paired with a valid tag.
            if (!we_q && !err_total) begin
              rdata_o <= {data_rdata_i, rdata_lo_q};
              rtag_o  <= tag_lo_q & data_tag_i;
            end else begin
              rdata_o <= '0;
              rtag_o  <= 1'b0;
            end
            state_q <= DONE;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_cheri_cap_lsu.sv
// tb_ibex_cheri_cap_lsu
// Scoreboard bench for the capability LSU. Each stimulus call does three
// things: it computes the expected completion from a word-level memory model,
// it queues the bus beats the access should produce, and it raises the
// request. A bus responder grants and answers each beat and checks the
// request fields against the queued beat. A monitor pops the expected
// completion whenever valid_o pulses and compares it with the DUT output.
module tb_ibex_cheri_cap_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [63:0] wdata_i;
  logic        wtag_i;
  logic        busy_o;
  logic        valid_o;
  logic [63:0] rdata_o;
  logic        rtag_o;
  logic        err_o;
  logic        misaligned_o;
  logic        data_req_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic        data_err_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_tag_o;
  logic [31:0] data_rdata_i;
  logic        data_tag_i;

`ifdef IBEX_CHERI_CAP_LSU_ERR_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  typedef struct {
    bit          is_load;
    bit          mis;
    bit          err;
    logic [63:0] rdata;
    bit          rtag;
    int          lat;
    int          issue_cyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    bit          tag;
    bit          err;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] rdata;
    bit          rtag;
  } beat_t;

  exp_t  exp_q[$];
  beat_t beat_q[$];

  logic [31:0] mem [logic [31:0]];
  bit          mtag [logic [31:0]];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Responder state
  bit          pend = 1'b0;
  int          pend_dly;
  logic [31:0] pend_data;
  bit          pend_tag;
  bit          pend_err;
  int          wait_cnt = 0;
  bit          hi_granted = 1'b0;

  ibex_cheri_cap_lsu dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .wtag_i       (wtag_i),
    .busy_o       (busy_o),
    .valid_o      (valid_o),
    .rdata_o      (rdata_o),
    .rtag_o       (rtag_o),
    .err_o        (err_o),
    .misaligned_o (misaligned_o),
    .data_req_o   (data_req_o),
    .data_gnt_i   (data_gnt_i),
    .data_rvalid_i(data_rvalid_i),
    .data_err_i   (data_err_i),
    .data_addr_o  (data_addr_o),
    .data_we_o    (data_we_o),
    .data_be_o    (data_be_o),
    .data_wdata_o (data_wdata_o),
    .data_tag_o   (data_tag_o),
    .data_rdata_i (data_rdata_i),
    .data_tag_i   (data_tag_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Compare one value and record the outcome
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Memory contents that have never been written are a fixed function of the address
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic bit tag_rd(input logic [31:0] a);
    if (mtag.exists(a)) return mtag[a];
    return 1'b1;
  endfunction

  // Bus responder. It runs just after each rising edge and decides the bus
  // inputs for the current cycle. A beat is granted after its planned stall
  // and answered after its planned response delay. On every cycle that
  // data_req_o is high, the request fields are checked against the planned
  // beat.
  always @(posedge clk_i) begin
    beat_t b;
    #1;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_err_i    = 1'b0;
    data_rdata_i  = $urandom;
    data_tag_i    = 1'($urandom);
    if (pend) begin
      if (pend_dly == 0) begin
        data_rvalid_i = 1'b1;
        data_rdata_i  = pend_data;
        data_tag_i    = pend_tag;
        data_err_i    = pend_err;
        pend          = 1'b0;
      end else begin
        pend_dly--;
      end
    end
    if (data_req_o && !rst_i) begin
      if (beat_q.size() == 0) begin
        checkOutput("unexpected_bus_req", 64'(data_req_o), 64'd0);
      end else begin
        b = beat_q[0];
        checkOutput("bus_addr", 64'(data_addr_o), 64'(b.addr));
        checkOutput("bus_we", 64'(data_we_o), 64'(b.we));
        checkOutput("bus_be", 64'(data_be_o), 64'hF);
        if (b.we) begin
          checkOutput("bus_wdata", 64'(data_wdata_o), 64'(b.wdata));
          checkOutput("bus_wtag", 64'(data_tag_o), 64'(b.tag));
        end
        if (wait_cnt >= b.gnt_dly) begin
          data_gnt_i = 1'b1;
          wait_cnt   = 0;
          void'(beat_q.pop_front());
          pend      = 1'b1;
          pend_dly  = b.rv_dly;
          pend_data = b.rdata;
          pend_tag  = b.rtag;
          pend_err  = b.err;
          if (b.addr[2]) hi_granted = 1'b1;
        end else begin
          wait_cnt++;
        end
      end
    end else if (!pend && !data_rvalid_i) begin
      // Stray grants while nothing is requested must be ignored
      data_gnt_i = ($urandom_range(0, 3) == 0);
    end
  end

  // Monitor: every completion pulse is matched against the oldest expectation
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i && valid_o) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_valid", 64'(valid_o), 64'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("misaligned", 64'(misaligned_o), 64'(e.mis));
        checkOutput("err", 64'(err_o), 64'(e.err));
        if (e.is_load) begin
          checkOutput("rdata", rdata_o, e.rdata);
          checkOutput("rtag", 64'(rtag_o), 64'(e.rtag));
        end
        if (e.lat >= 0) checkOutput("latency", 64'(cyc - e.issue_cyc), 64'(e.lat));
      end
    end
  end

  // Plan one access from the memory model, raise the request, and optionally
  // wait for it to complete. While the unit is busy, req_i is toggled with
  // junk requests that must be ignored.
  task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [63:0] wdata,
                               input bit wtag, input int gl, input int rl, input int gh,
                               input int rh, input bit el, input bit eh, input int lat,
                               input bit do_wait);
    exp_t  e;
    beat_t blo, bhi;
    bit    issue_hi;
    int    n;
    e.is_load   = !we;
    e.lat       = lat;
    e.issue_cyc = cyc;
    e.rdata     = 64'd0;
    e.rtag      = 1'b0;
    e.err       = 1'b0;
    e.mis       = (addr[2:0] != 3'd0);
    if (!e.mis) begin
      issue_hi = !(ABORT && el);
      e.err    = el | (issue_hi & eh);
      blo = '{addr, we, wdata[31:0], wtag, el, gl, rl, mem_rd(addr), tag_rd(addr)};
      bhi = '{addr + 32'd4, we, wdata[63:32], wtag, eh, gh, rh,
              mem_rd(addr + 32'd4), tag_rd(addr + 32'd4)};
      if (!we && !e.err) begin
        e.rdata = {bhi.rdata, blo.rdata};
        e.rtag  = blo.rtag & bhi.rtag;
      end
      beat_q.push_back(blo);
      if (issue_hi) beat_q.push_back(bhi);
      if (we) begin
        mem[addr]          = wdata[31:0];
        mem[addr + 32'd4]  = wdata[63:32];
        mtag[addr]         = wtag;
        mtag[addr + 32'd4] = wtag;
      end
    end
    exp_q.push_back(e);
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = addr;
    wdata_i = wdata;
    wtag_i  = wtag;
    if (!do_wait) begin
      @(negedge clk_i);
      req_i = 1'b0;
      return;
    end
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
      if (busy_o) begin
        req_i   = 1'($urandom);
        we_i    = 1'($urandom);
        addr_i  = $urandom;
        wdata_i = {$urandom, $urandom};
        wtag_i  = 1'($urandom);
      end
    end while (busy_o && n < 300);
    req_i = 1'b0;
    if (n >= 300) begin
      checkOutput("access_timeout", 64'(busy_o), 64'd0);
      exp_q.delete();
      beat_q.delete();
    end else begin
      checkOutput("expect_drained", 64'(exp_q.size()), 64'd0);
      checkOutput("beats_drained", 64'(beat_q.size()), 64'd0);
      exp_q.delete();
      beat_q.delete();
    end
  endtask

  initial begin
    int n;
    rst_i = 1'b1;
    req_i = 1'b0;
    we_i = 1'b0;
    addr_i = '0;
    wdata_i = '0;
    wtag_i = 1'b0;
    data_gnt_i = 1'b0;
    data_rvalid_i = 1'b0;
    data_err_i = 1'b0;
    data_rdata_i = '0;
    data_tag_i = 1'b0;
    repeat (3) @(negedge clk_i);

    // Reset values
    checkOutput("rst_busy", 64'(busy_o), 64'd0);
    checkOutput("rst_valid", 64'(valid_o), 64'd0);
    checkOutput("rst_data_req", 64'(data_req_o), 64'd0);
    checkOutput("rst_be", 64'(data_be_o), 64'd0);
    checkOutput("rst_addr", 64'(data_addr_o), 64'd0);
    checkOutput("rst_rdata", rdata_o, 64'd0);
    checkOutput("rst_flags", {61'd0, rtag_o, err_o, misaligned_o}, 64'd0);
    checkOutput("rst_wr", {31'd0, data_we_o, data_tag_o, data_wdata_o}, 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    $display("[TB] directed accesses");
    mem[32'h1000] = 32'hDEADBEEF;  mtag[32'h1000] = 1'b1;
    mem[32'h1004] = 32'h12345678;  mtag[32'h1004] = 1'b1;
    applyStimulus(1'b0, 32'h1000, 64'd0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 5, 1'b1);
    applyStimulus(1'b1, 32'h2008, 64'hAAAA5555_0F0F1234, 1'b1, 3, 0, 3, 0, 1'b0, 1'b0, -1, 1'b1);
    applyStimulus(1'b0, 32'h2008, 64'd0, 1'b0, 1, 2, 0, 1, 1'b0, 1'b0, -1, 1'b1);
    mem[32'h1010] = 32'hCAFEF00D;  mtag[32'h1010] = 1'b1;
    mem[32'h1014] = 32'h0BADC0DE;  mtag[32'h1014] = 1'b0;
    applyStimulus(1'b0, 32'h1010, 64'd0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 5, 1'b1);
    applyStimulus(1'b0, 32'h3004, 64'd0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1, 1'b1);
    applyStimulus(1'b0, 32'h1000, 64'd0, 1'b0, 0, 0, 0, 0, 1'b1, 1'b0, -1, 1'b1);
    applyStimulus(1'b0, 32'h1000, 64'd0, 1'b0, 0, 1, 0, 0, 1'b0, 1'b1, -1, 1'b1);

    // Reset while waiting for the high-beat response; that response then
    // arrives late and must be ignored
    $display("[TB] reset during high-beat wait");
    hi_granted = 1'b0;
    applyStimulus(1'b0, 32'h1020, 64'd0, 1'b0, 0, 0, 0, 8, 1'b0, 1'b0, -1, 1'b0);
    n = 0;
    while (!hi_granted && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("hi_beat_granted", 64'(hi_granted), 64'd1);
    @(negedge clk_i);
    checkOutput("waiting_hi_busy", {62'd0, busy_o, data_req_o}, 64'd2);
    rst_i = 1'b1;
    #1;
    checkOutput("async_rst_busy", 64'(busy_o), 64'd0);
    checkOutput("async_rst_req", 64'(data_req_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    exp_q.delete();
    beat_q.delete();
    repeat (12) begin
      @(negedge clk_i);
      checkOutput("post_rst_valid", 64'(valid_o), 64'd0);
    end
    checkOutput("post_rst_busy", 64'(busy_o), 64'd0);
    checkOutput("post_rst_rdata", rdata_o, 64'd0);
    checkOutput("post_rst_flags", {61'd0, rtag_o, err_o, misaligned_o}, 64'd0);

    $display("[TB] randomized accesses");
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = 32'h1000 + 32'($urandom_range(0, 15)) * 8;
      if ($urandom_range(0, 6) == 0) a = a + 32'($urandom_range(1, 7));
      applyStimulus(1'($urandom), a, {$urandom, $urandom}, 1'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), -1, 1'b1);
    end

    repeat (4) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
